// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word-wide FIFO; each word is sent as WORD_BYTES
// back-to-back 8N1 frames, with byte order selected by LSB_FIRST.
module uart_tx_fifo #(
    parameter int unsigned PERIOD     = 868,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WORD_BYTES = 1,
    parameter int unsigned LSB_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] in,
    input  logic                    valid,
    output logic                    ready,
    output logic                    out,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned WW    = 8*WORD_BYTES;
    localparam int unsigned TW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned BW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [TW-1:0]       T_LAST    = TW'(PERIOD-1);
    localparam logic [BW-1:0]       BYTE_LAST = BW'(WORD_BYTES-1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state;
    logic [WW-1:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [TW-1:0]           timer;
    logic [2:0]              bit_idx;
    logic [BW-1:0]           byte_idx;
    logic [WW-1:0]           word_reg;
    logic [7:0]              cur_byte;
    logic                    push;
    logic                    pop;
    logic                    bit_end;
    logic                    word_end;

    // Full blocks a push even when a pop happens on the same edge.
    assign ready    = (count != FULL);
    assign push     = valid && ready;
    assign bit_end  = (timer == T_LAST);
    assign word_end = (state == STOP) && bit_end && (byte_idx == BYTE_LAST);
    assign pop      = (count != '0) && ((state == IDLE) || word_end);
    assign busy     = (state != IDLE) || (count != '0);

    // Byte currently on the wire, chosen by byte_idx and the configured order.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (byte_idx == BW'(i)) begin
                if (LSB_FIRST != 0)
                    cur_byte = word_reg[i*8 +: 8];
                else
                    cur_byte = word_reg[(int'(WORD_BYTES)-1-i)*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (valid && !ready)
                overflow <= 1'b1;
        end
    end

    // Serializer; out is set to the level of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out      <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out   <= 1'b1;
                    timer <= '0;
                    if (pop) begin
                        word_reg <= mem[rd_ptr];
                        byte_idx <= '0;
                        state    <= START;
                        out      <= 1'b0;
                    end
                end
                START: begin
                    timer <= bit_end ? '0 : timer + 1'b1;
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        out     <= cur_byte[0];
                    end
                end
                DATA: begin
                    timer <= bit_end ? '0 : timer + 1'b1;
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                            out     <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            out     <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    timer <= bit_end ? '0 : timer + 1'b1;
                    if (bit_end) begin
                        if (byte_idx != BYTE_LAST) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                            out      <= 1'b0;
                        end else begin
                            byte_idx <= '0;
                            if (pop) begin
                                word_reg <= mem[rd_ptr];
                                state    <= START;
                                out      <= 1'b0;
                            end else begin
                                state <= IDLE;
                                out   <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (LSB-first and MSB-first) share the
// stimulus and are checked every cycle against a line-level waveform model.
module tb_uart_tx_fifo;

    localparam int P  = 4;
    localparam int DL = 2;
    localparam int WB = 2;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [8*WB-1:0] din;
    logic            valid;
    logic            ready0, out0, busy0, ovf0;
    logic            ready1, out1, busy1, ovf1;
    logic [DL:0]     count0, count1;

    int total = 0;
    int bad   = 0;

    // Model: one entry per future cycle {word_start, lsb_first_level, msb_first_level}.
    logic [2:0] q[$];
    int         m_count;
    bit         m_ovf;
    bit         m_active;
    logic       exp_l, exp_m;

    uart_tx_fifo #(.PERIOD(P), .DEPTH_LOG2(DL), .WORD_BYTES(WB), .LSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .in(din), .valid(valid), .ready(ready0),
        .out(out0), .count(count0), .busy(busy0), .overflow(ovf0)
    );

    uart_tx_fifo #(.PERIOD(P), .DEPTH_LOG2(DL), .WORD_BYTES(WB), .LSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .in(din), .valid(valid), .ready(ready1),
        .out(out1), .count(count1), .busy(busy1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Append the full line waveform of one word for both byte orders.
    task automatic append_word(input logic [8*WB-1:0] w);
        for (int k = 0; k < WB; k++) begin
            logic [7:0] bl;
            logic [7:0] bm;
            bl = w[k*8 +: 8];
            bm = w[(WB-1-k)*8 +: 8];
            for (int j = 0; j < 10*P; j++) begin
                int   bp;
                logic vl;
                logic vm;
                bp = j / P;
                if (bp == 0) begin
                    vl = 1'b0; vm = 1'b0;
                end else if (bp == 9) begin
                    vl = 1'b1; vm = 1'b1;
                end else begin
                    vl = bl[3'(bp-1)];
                    vm = bm[3'(bp-1)];
                end
                q.push_back({(k == 0 && j == 0), vl, vm});
            end
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_count  = 0;
        m_ovf    = 0;
        m_active = 0;
    endtask

    // One clock: update the model at the edge, check all outputs at the falling edge.
    task automatic step();
        bit         acc;
        logic [2:0] e;
        @(posedge clk);
        acc = valid && (m_count != DEPTH);
        if (valid && m_count == DEPTH)
            m_ovf = 1;
        if (q.size() > 0) begin
            e        = q.pop_front();
            exp_l    = e[1];
            exp_m    = e[0];
            m_active = 1;
            if (e[2])
                m_count--;
        end else begin
            exp_l    = 1'b1;
            exp_m    = 1'b1;
            m_active = 0;
        end
        if (acc) begin
            m_count++;
            append_word(din);
        end
        @(negedge clk);
        chk("out_lsb_first", 32'(out0), 32'(exp_l));
        chk("out_msb_first", 32'(out1), 32'(exp_m));
        chk("count", 32'(count0), 32'(m_count));
        chk("ready", 32'(ready0), 32'(m_count != DEPTH));
        chk("busy", 32'(busy0), 32'(m_active || m_count != 0));
        chk("busy_msb", 32'(busy1), 32'(m_active || m_count != 0));
        chk("overflow", 32'(ovf0), 32'(m_ovf));
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        valid = 1'b0;
        while ((q.size() != 0 || m_count != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_bound", 32'(q.size()), 32'd0);
        step();
        step();
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        din   = '0;
        model_clear();
        exp_l = 1'b1;
        exp_m = 1'b1;
        #1;
        chk("rst_out", 32'(out0), 32'd1);
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_overflow", 32'(ovf0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single word, both byte orders.
        valid = 1'b1; din = 16'hA55A;
        step();
        valid = 1'b0;
        drain(400);

        // Back-to-back words.
        valid = 1'b1; din = 16'h1111;
        step();
        din = 16'h2222;
        step();
        valid = 1'b0;
        drain(400);

        // Six consecutive pushes from idle: five accepted, then overflow.
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 16'(16'h0101 * (i + 1));
            step();
        end
        valid = 1'b0;
        chk("full_count", 32'(count0), 32'd4);
        chk("full_ready", 32'(ready0), 32'd0);
        chk("full_overflow", 32'(ovf0), 32'd1);
        drain(1000);
        chk("overflow_sticky", 32'(ovf0), 32'd1);

        // Reset during data bit 3 of the first byte with two words queued.
        valid = 1'b1; din = 16'h3C5A;
        step();
        din = 16'h1234;
        step();
        din = 16'h5678;
        step();
        valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out", 32'(out0), 32'd1);
        chk("abort_count", 32'(count0), 32'd0);
        chk("abort_overflow", 32'(ovf0), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic: sparse, then dense enough to fill and overflow.
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 39) == 0);
            din   = 16'($urandom);
            step();
        end
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            din   = 16'($urandom);
            step();
        end
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
